// File: rtl/sqnl_pkg.sv
// Shared mode encoding and width helpers for the pipelined SQNL activation array.
package sqnl_pkg;

  localparam logic [1:0] MODE_SQNL  = 2'd0;
  localparam logic [1:0] MODE_SIGN  = 2'd1;
  localparam logic [1:0] MODE_HTANH = 2'd2;

  // Y = sc*2^(F+2) - sc*|sc| is exact in this many signed bits
  function automatic int prod_width(input int frac_bits);
    return 2 * frac_bits + 4;
  endfunction

  function automatic int sqnl_shift(input int frac_bits, input int output_bits);
    return 2 * frac_bits + 3 - output_bits;
  endfunction

  function automatic int htanh_shift(input int frac_bits, input int output_bits);
    return frac_bits + 1 - output_bits;
  endfunction

endpackage

// File: rtl/sqnl_pipe_array_lane.sv
// One channel of the activation pipeline: S1 clamps the sum, S2 forms the
// SQNL product, S3 shifts, clamps and flags saturation.
module sqnl_lane
  import sqnl_pkg::*;
#(
  parameter int SUM_BITS    = 8,
  parameter int FRAC_BITS   = 4,
  parameter int OUTPUT_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic signed [SUM_BITS-1:0]    sum,
  output logic signed [OUTPUT_BITS-1:0] act,
  output logic                          sat
);

  localparam int SC_W  = FRAC_BITS + 3;
  localparam int PW    = prod_width(FRAC_BITS);
  localparam int SQ_SH = sqnl_shift(FRAC_BITS, OUTPUT_BITS);
  localparam int HT_SH = htanh_shift(FRAC_BITS, OUTPUT_BITS);

  localparam logic signed [SUM_BITS:0]      T_X   = (SUM_BITS + 1)'(2 ** (FRAC_BITS + 1));
  localparam logic signed [SC_W-1:0]        T_SC  = SC_W'(2 ** (FRAC_BITS + 1));
  localparam logic signed [PW-1:0]          MAX_P = PW'(2 ** (OUTPUT_BITS - 1) - 1);
  localparam logic signed [PW-1:0]          MIN_P = PW'(-(2 ** (OUTPUT_BITS - 1)));
  localparam logic signed [SUM_BITS-1:0]    MAX_S = SUM_BITS'(2 ** (OUTPUT_BITS - 1) - 1);
  localparam logic signed [SUM_BITS-1:0]    MIN_S = SUM_BITS'(-(2 ** (OUTPUT_BITS - 1)));
  localparam logic signed [OUTPUT_BITS-1:0] MAX_O = OUTPUT_BITS'(2 ** (OUTPUT_BITS - 1) - 1);
  localparam logic signed [OUTPUT_BITS-1:0] MIN_O = OUTPUT_BITS'(-(2 ** (OUTPUT_BITS - 1)));

  logic signed [SUM_BITS-1:0]    s1_sum_reg, s2_sum_reg;
  logic signed [SC_W-1:0]        s1_sc_reg;
  logic                          s1_big_reg, s2_big_reg;
  logic [1:0]                    s1_mode_reg, s2_mode_reg;
  logic signed [PW-1:0]          s2_y_reg;
  logic signed [OUTPUT_BITS-1:0] act_reg;
  logic                          sat_reg;

  logic signed [SUM_BITS:0]      sum_x;
  logic                          big;
  logic signed [SC_W-1:0]        sc_next;
  logic signed [PW-1:0]          sc_w, sc_abs, y_next, p_sq;
  logic signed [SUM_BITS-1:0]    p_ht;
  logic signed [OUTPUT_BITS-1:0] act_next;
  logic                          sat_next;

  // One extra bit so that +T is representable even when SUM_BITS = FRAC_BITS+2
  always_comb begin
    sum_x = {sum[SUM_BITS-1], sum};
    big   = (sum_x >= T_X) || (sum_x <= -T_X);
    if (!big)
      sc_next = sum_x[SC_W-1:0];
    else if (sum_x[SUM_BITS])
      sc_next = -T_SC;
    else
      sc_next = T_SC;
  end

  // sc*2^(F+2) may wrap at sc=+T; the modular difference is still exact
  always_comb begin
    sc_w   = PW'(s1_sc_reg);
    sc_abs = sc_w[PW-1] ? -sc_w : sc_w;
    y_next = (sc_w <<< (FRAC_BITS + 2)) - sc_w * sc_abs;
  end

  always_comb begin
    p_sq     = s2_y_reg >>> SQ_SH;
    p_ht     = s2_sum_reg >>> HT_SH;
    act_next = '0;
    sat_next = 1'b0;
    case (s2_mode_reg)
      MODE_SQNL: begin
        if (p_sq > MAX_P)      act_next = MAX_O;
        else if (p_sq < MIN_P) act_next = MIN_O;
        else                   act_next = p_sq[OUTPUT_BITS-1:0];
        sat_next = s2_big_reg || (p_sq > MAX_P) || (p_sq < MIN_P);
      end
      MODE_SIGN: act_next = s2_sum_reg[SUM_BITS-1] ? MIN_O : MAX_O;
      MODE_HTANH: begin
        if (p_ht > MAX_S)      act_next = MAX_O;
        else if (p_ht < MIN_S) act_next = MIN_O;
        else                   act_next = p_ht[OUTPUT_BITS-1:0];
        sat_next = (p_ht > MAX_S) || (p_ht < MIN_S);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sum_reg  <= '0;
      s1_sc_reg   <= '0;
      s1_big_reg  <= 1'b0;
      s1_mode_reg <= '0;
      s2_sum_reg  <= '0;
      s2_y_reg    <= '0;
      s2_big_reg  <= 1'b0;
      s2_mode_reg <= '0;
      act_reg     <= '0;
      sat_reg     <= 1'b0;
    end else if (en) begin
      s1_sum_reg  <= sum;
      s1_sc_reg   <= sc_next;
      s1_big_reg  <= big;
      s1_mode_reg <= mode;
      s2_sum_reg  <= s1_sum_reg;
      s2_y_reg    <= y_next;
      s2_big_reg  <= s1_big_reg;
      s2_mode_reg <= s1_mode_reg;
      act_reg     <= act_next;
      sat_reg     <= sat_next;
    end
  end

  assign act = act_reg;
  assign sat = sat_reg;

endmodule

// File: rtl/sqnl_pipe_array.sv
// Multi-channel pipelined activation with valid/ready flow control and a
// saturating count of saturated output beats.
module sqnl_pipe_array
  import sqnl_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SUM_BITS     = 8,
  parameter int FRAC_BITS    = 4,
  parameter int OUTPUT_BITS  = 4,
  parameter int SAT_CNT_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mode,
  input  logic [N_CH*SUM_BITS-1:0]      in_sum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_CH*OUTPUT_BITS-1:0]   out_act,
  output logic [N_CH-1:0]               out_sat,
  input  logic                          sat_clr,
  output logic [SAT_CNT_BITS-1:0]       sat_count
);

  logic                    advance;
  logic                    v1_reg, v2_reg, out_valid_reg;
  logic [SAT_CNT_BITS-1:0] sat_count_reg;

  // The whole pipe moves in lockstep; bubbles are carried, not squeezed out
  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      v1_reg        <= in_valid;
      v2_reg        <= v1_reg;
      out_valid_reg <= v2_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      sqnl_lane #(
        .SUM_BITS   (SUM_BITS),
        .FRAC_BITS  (FRAC_BITS),
        .OUTPUT_BITS(OUTPUT_BITS)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .mode(in_mode),
        .sum (in_sum[gi*SUM_BITS +: SUM_BITS]),
        .act (out_act[gi*OUTPUT_BITS +: OUTPUT_BITS]),
        .sat (out_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || sat_clr)
      sat_count_reg <= '0;
    else if (out_valid_reg && out_ready && (|out_sat) && !(&sat_count_reg))
      sat_count_reg <= sat_count_reg + SAT_CNT_BITS'(1);
  end

  assign out_valid = out_valid_reg;
  assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_sqnl_pipe_array.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops and
// compares on every output handshake.
module tb_sqnl_pipe_array;

  localparam int N  = 4;
  localparam int SB = 8;
  localparam int F  = 4;
  localparam int OB = 4;
  localparam int T  = 2 ** (F + 1);
  localparam int MX = 2 ** (OB - 1) - 1;
  localparam int MN = -(2 ** (OB - 1));

  typedef struct {
    logic [N*OB-1:0] act;
    logic [N-1:0]    sat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic            sat_clr = 1'b0;
  logic [1:0]      in_mode = 2'd0;
  logic [N*SB-1:0] in_sum = '0;

  logic            in_ready, out_valid, in_ready_c, out_valid_c;
  logic [N*OB-1:0] out_act, out_act_c;
  logic [N-1:0]    out_sat, out_sat_c;
  logic [15:0]     sat_count;
  logic [2:0]      sat_count_c;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_hs = 0;
  int   cnt16 = 0;
  int   cnt3 = 0;
  bit   bp_rand = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sqnl_pipe_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_sum(in_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_act(out_act), .out_sat(out_sat),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  sqnl_pipe_array #(.SAT_CNT_BITS(3)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_mode(in_mode), .in_sum(in_sum), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_act(out_act_c), .out_sat(out_sat_c),
    .sat_clr(sat_clr), .sat_count(sat_count_c)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int floor_div(input int a, input int d);
    int r;
    r = a / d;
    if ((a % d != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  function automatic int clampi(input int v);
    return (v > MX) ? MX : ((v < MN) ? MN : v);
  endfunction

  // Reference activation straight from the real-valued definitions
  function automatic exp_t model(input logic [1:0] mode, input logic [N*SB-1:0] sums);
    exp_t e;
    int s, sc, y, p, o;
    bit st;
    e.act = '0;
    e.sat = '0;
    for (int k = 0; k < N; k++) begin
      s  = int'($signed(sums[k*SB +: SB]));
      o  = 0;
      st = 0;
      case (mode)
        2'd0: begin
          sc = (s > T) ? T : ((s < -T) ? -T : s);
          y  = sc * 2 ** (F + 2) - sc * iabs(sc);
          p  = floor_div(y, 2 ** (2 * F + 3 - OB));
          o  = clampi(p);
          st = (iabs(s) >= T) || (p > MX) || (p < MN);
        end
        2'd1: o = (s >= 0) ? MX : MN;
        2'd2: begin
          p  = floor_div(s, 2 ** (F + 1 - OB));
          o  = clampi(p);
          st = (p > MX) || (p < MN);
        end
        default: o = 0;
      endcase
      e.act[k*OB +: OB] = OB'(o);
      e.sat[k] = st;
    end
    return e;
  endfunction

  function automatic logic [N*SB-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [N*SB-1:0] r;
    r[0*SB +: SB] = SB'(a);
    r[1*SB +: SB] = SB'(b);
    r[2*SB +: SB] = SB'(c);
    r[3*SB +: SB] = SB'(d);
    return r;
  endfunction

  function automatic logic [N*OB-1:0] pack_act(input int a, input int b, input int c, input int d);
    logic [N*OB-1:0] r;
    r[0*OB +: OB] = OB'(a);
    r[1*OB +: OB] = OB'(b);
    r[2*OB +: OB] = OB'(c);
    r[3*OB +: OB] = OB'(d);
    return r;
  endfunction

  function automatic int rand_sum();
    int edges[11] = '{-128, -33, -32, -31, -1, 0, 1, 31, 32, 33, 127};
    if ($urandom_range(0, 9) < 3) return edges[$urandom_range(0, 10)];
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Monitor: pop on output handshake, push on input acceptance, track counters
  initial begin
    exp_t e;
    bit rst_prev = 0, stall_prev = 0, hs_sat;
    logic [N*OB-1:0] act_prev = '0;
    logic [N-1:0] sat_prev = '0;
    forever begin
      @(negedge clk);
      hs_sat = 0;
      if (rst) begin
        q.delete();
        cnt16 = 0;
        cnt3 = 0;
      end else begin
        if (rst_prev) begin
          chk("rst_out_valid", out_valid, 1'b0);
          chk("rst_out_act", out_act, '0);
          chk("rst_out_sat", out_sat, '0);
          chk("rst_in_ready", in_ready, 1'b1);
        end
        if (stall_prev) begin
          chk("stall_valid_held", out_valid, 1'b1);
          chk("stall_act_stable", out_act, act_prev);
          chk("stall_sat_stable", out_sat, sat_prev);
        end
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
        chk("sat_count", sat_count, cnt16);
        chk("sat_count_3b", sat_count_c, cnt3);
        if (out_valid && out_ready) begin
          n_hs++;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got out_act %0h with empty scoreboard at %0t", out_act, $time);
          end else begin
            e = q.pop_front();
            chk("out_act", out_act, e.act);
            chk("out_sat", out_sat, e.sat);
            chk("out_act_3b", out_act_c, e.act);
            chk("out_sat_3b", {out_valid_c, out_sat_c}, {1'b1, e.sat});
            hs_sat = |e.sat;
          end
        end
        if (in_valid && in_ready) begin
          n_acc++;
          q.push_back(model(in_mode, in_sum));
          chk("in_ready_3b", in_ready_c, 1'b1);
        end
        if (sat_clr) begin
          cnt16 = 0;
          cnt3 = 0;
        end else if (hs_sat) begin
          if (cnt16 < 65535) cnt16++;
          if (cnt3 < 7) cnt3++;
        end
      end
      rst_prev   = rst;
      stall_prev = !rst && out_valid && !out_ready;
      act_prev   = out_act;
      sat_prev   = out_sat;
    end
  end

  // Random backpressure and occasional counter clears
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_rand) begin
      out_ready = ($urandom_range(0, 9) < 7);
      sat_clr   = ($urandom_range(0, 29) == 0);
    end
  end

  task automatic send(input logic [1:0] mode, input logic [N*SB-1:0] sums);
    bit acc = 0;
    in_mode  = mode;
    in_sum   = sums;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles, expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while ((q.size() != 0 || out_valid) && i < 300);
    if (q.size() != 0 || out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors and first-beat latency
    send(2'd0, pack4(16, -16, 0, 32));
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", lat, 3);
    chk("t1_act", out_act, pack_act(6, -6, 0, 7));
    chk("t1_sat", out_sat, 4'b1000);
    drain();
    chk("t1_count", sat_count, 16'd1);
    send(2'd0, pack4(-32, 100, -128, 8));
    send(2'd1, pack4(0, -1, 127, -128));
    send(2'd2, pack4(10, 40, -40, -3));
    send(2'd3, pack4(100, -100, 5, -5));
    drain();
    chk("t3_count", sat_count, 16'd3);

    // Stall window while a stream is in flight
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(2'($urandom_range(0, 3)), pack4(rand_sum(), rand_sum(), rand_sum(), rand_sum()));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_beats_in_out", n_hs, n_acc);

    // Narrow counter saturates, then clear wins over a saturated handshake
    for (int i = 0; i < 10; i++) send(2'd0, pack4(100, 100, 100, 100));
    drain();
    chk("cnt3_hold", sat_count_c, 3'd7);
    send(2'd0, pack4(100, 0, 0, 0));
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    @(negedge clk);
    chk("clr_priority", sat_count, 16'd0);
    chk("clr_priority_3b", sat_count_c, 3'd0);
    drain();

    // Randomized traffic with backpressure
    bp_rand = 1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(2'($urandom_range(0, 3)), pack4(rand_sum(), rand_sum(), rand_sum(), rand_sum()));
    end
    bp_rand = 0;
    out_ready = 1'b1;
    sat_clr = 1'b0;
    drain();

    // Reset with beats in flight
    send(2'd0, pack4(100, 1, 2, 3));
    send(2'd2, pack4(40, 1, 2, 3));
    send(2'd1, pack4(-1, 1, 2, 3));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send(2'd2, pack4(10, 40, -40, -3));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before 2ms");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
